qpsk_frame_loader: RTL
======================

// Module: qpsk_frame_loader
// PURPOSE
//  Collects QPSK symbols from the constellation mapper (+/-46341 per rail, Q16 1/sqrt2) into one
//  N-symbol frame. Replays the frame to the downstream IFFT in bit-reversed (or natural) order.
//  Sits between the mapper and the IFFT input. Valid/ready handshake on both sides.
// PARAMETERS
//  LOG2N   6    log2 of frame length N (N = 64 symbols)
//  DW      32   signed sample width per rail (re, im)
//  BITREV  1    1: output index = bit-reverse(rd_idx); 0: natural order
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  in_valid     in   1      mapper symbol valid
//  in_ready     out  1      loader can accept a symbol
//  in_re        in   DW     signed real part from mapper
//  in_im        in   DW     signed imaginary part from mapper
//  out_valid    out  1      symbol presented to IFFT
//  out_ready    in   1      IFFT accepts symbol
//  out_re       out  DW     signed real part
//  out_im       out  DW     signed imaginary part
//  out_first    out  1      high with the first symbol of a frame (rd_idx == 0)
//  out_last     out  1      high with the last symbol of a frame (rd_idx == N-1)
//  frame_count  out  16     completed output frames, wraps 65535 -> 0
// BEHAVIOUR
//  - Reset is asynchronous and active-high on rst. Clock is clk. One clock domain only.
//  - Reset values: state=FILL, wr_idx=0, rd_idx=0, frame_count=0.
//    Outputs after reset: in_ready=1, out_valid=0, out_first=0, out_last=0, out_re=out_im=0.
//    Frame RAM contents are not reset.
//  - Transfer rules:
//    - Input transfer: in_valid & in_ready on a rising edge.
//    - Output transfer: out_valid & out_ready on a rising edge.
//  - FILL state:
//    - in_ready=1, out_valid=0.
//    - Each input transfer writes {in_re,in_im} to mem[wr_idx], then wr_idx++.
//    - The transfer with wr_idx==N-1 moves the state to DRAIN and clears wr_idx to 0.
//    - in_valid gaps are allowed and stall the fill.
//  - DRAIN state:
//    - in_ready=0. in_valid is ignored and nothing is written.
//    - out_valid=1. {out_re,out_im} = mem[addr], addr = BITREV ? bitrev_LOG2N(rd_idx) : rd_idx.
//    - Each output transfer increments rd_idx.
//    - The transfer with rd_idx==N-1 clears rd_idx, increments frame_count, and returns to FILL.
//  - Latency: out_valid rises the cycle after the Nth input transfer.
//    Minimum frame period is 2N cycles (N fill + N drain). There is no overlap.
//  - Backpressure: while out_valid & !out_ready, out_re, out_im, out_first and out_last stay
//    stable. rd_idx does not advance.
//  - When out_valid=0, out_re, out_im, out_first and out_last are driven to 0.
//  - Arithmetic: data passes through bit-exact, signed DW. No scaling and no saturation.
//    Index counters are LOG2N bits and wrap naturally.
//  - Reset mid-frame (FILL or DRAIN): the partial frame is discarded and the block returns to
//    reset values immediately. frame_count does not count the aborted frame.
// STRUCTURE
//  - Shared header qpsk_defs.vh holds:
//    - DW default
//    - QPSK_AMP = 46341
//    - LOG2N default
//    - FILL/DRAIN state encodings (1-bit localparams)
//    - the bitrev function (generic in LOG2N)
//  - Sub-module frame_ram:
//    - N x 2*DW register array, parameterised by LOG2N and DW
//    - 1 synchronous write port (we, waddr, wdata)
//    - 1 combinational read port (raddr, rdata)
//    - no reset
//  - Top level holds the FSM, the counters, frame_count and output gating.
// TESTING
//  1) rst pulse held 3 cycles -> in_ready=1, out_valid=0, frame_count=0, out_re=out_im=0.
//  2) LOG2N=3, BITREV=1: feed re=k, im=-k, k=0..7, out_ready=1 ->
//     - out_re sequence 0,4,2,6,1,5,3,7, each with im=-re
//     - out_first on 0, out_last on 7
//     - frame_count=1
//  3) LOG2N=3, BITREV=0, same stimulus -> out_re 0..7 in order. First output cycle is the one
//     after the 8th input transfer.
//  4) Backpressure: drop out_ready for 5 cycles while re=6 is shown ->
//     - out_valid=1 and out_re=6, out_im=-6 held all 5 cycles
//     - sequence resumes with 1
//  5) Drive in_valid=1, in_re=99 throughout DRAIN -> in_ready=0, and value 99 never appears.
//     The next frame starts at mem[0].
//  6) Assert rst after the 5th output of frame 2 ->
//     - out_valid drops asynchronously, frame_count=0
//     - a fresh 8-symbol frame then drains correctly with out_first on its first symbol.

Source files
------------

// File: rtl/qpsk_frame_loader_pkg.sv
// Shared definitions for the QPSK frame loader.
//   - default frame/sample geometry
//   - QPSK rail amplitude (Q16 1/sqrt2) produced by the upstream mapper
//   - loader state encoding
//   - generic bit-reversal helper used to build the replay address
package qpsk_frame_loader_pkg;

    localparam int unsigned DefaultDw    = 32;
    localparam int unsigned DefaultLog2n = 6;

    // Largest supported LOG2N; bitrev() works on this many bits.
    localparam int unsigned MaxLog2n     = 16;

    // Mapper output amplitude per rail: round(65536 / sqrt(2)).
    localparam int          QpskAmp      = 46341;

    typedef enum logic [0:0] {
        StFill  = 1'b0,
        StDrain = 1'b1
    } state_e;

    // Reverse the low 'width' bits of idx; bits at and above 'width' come back as zero.
    function automatic logic [MaxLog2n-1:0] bitrev(input logic [MaxLog2n-1:0] idx,
                                                   input int unsigned         width);
        logic [MaxLog2n-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxLog2n; i++) begin
            if (i < width) begin
                r[4'(i)] = idx[4'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/qpsk_frame_loader_if.sv
// Symbol stream bundle between the constellation mapper, the frame loader and the IFFT.
//   in_*  : mapper -> loader   (valid/ready, signed re/im)
//   out_* : loader -> IFFT     (valid/ready, signed re/im, frame first/last markers)
// Modports:
//   slave  : the loader side (accepts in_*, produces out_*)
//   master : the environment side (produces in_*, consumes out_*)
interface qpsk_frame_loader_if
    import qpsk_frame_loader_pkg::*;
#(
    parameter int unsigned DW = DefaultDw
);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;

    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic                 out_first;
    logic                 out_last;

    modport slave (
        input  in_valid,
        input  in_re,
        input  in_im,
        output in_ready,
        output out_valid,
        output out_re,
        output out_im,
        output out_first,
        output out_last,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_re,
        output in_im,
        input  in_ready,
        input  out_valid,
        input  out_re,
        input  out_im,
        input  out_first,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/qpsk_frame_loader_frame_ram.sv
// Frame buffer for the QPSK frame loader: 2**LOG2N words of 2*DW bits ({re, im}).
// Ports:
//   clk_i    : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data {re, im}
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
// Contents are deliberately not reset; the loader never reads a word it has not written
// in the current frame.
module qpsk_frame_loader_frame_ram
    import qpsk_frame_loader_pkg::*;
#(
    parameter int unsigned LOG2N = DefaultLog2n,
    parameter int unsigned DW    = DefaultDw
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [LOG2N-1:0]   waddr_i,
    input  logic [2*DW-1:0]    wdata_i,
    input  logic [LOG2N-1:0]   raddr_i,
    output logic [2*DW-1:0]    rdata_o
);

    localparam int unsigned Depth = 1 << LOG2N;

    logic [2*DW-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/qpsk_frame_loader.sv
// QPSK frame loader: collects N = 2**LOG2N mapper symbols into a frame buffer, then replays
// the whole frame to the IFFT in bit-reversed (BITREV=1) or natural (BITREV=0) order.
// Fill and drain never overlap, so the minimum frame period is 2N cycles.
// Ports:
//   clk           : single clock, rising edge
//   rst           : asynchronous active-high reset
//   bus_io        : symbol stream bundle (slave side), see qpsk_frame_loader_if
//   frame_count_o : number of completed output frames, wraps 65535 -> 0
module qpsk_frame_loader
    import qpsk_frame_loader_pkg::*;
#(
    parameter int unsigned LOG2N  = DefaultLog2n,
    parameter int unsigned DW     = DefaultDw,
    parameter bit          BITREV = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    qpsk_frame_loader_if.slave    bus_io,
    output logic [15:0]           frame_count_o
);

    localparam int unsigned      N       = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);

    state_e           state_q, state_d;
    logic [LOG2N-1:0] wr_idx_q, wr_idx_d;
    logic [LOG2N-1:0] rd_idx_q, rd_idx_d;
    logic [15:0]      frame_count_q, frame_count_d;

    logic             filling;
    logic             draining;
    logic             in_xfer;
    logic             out_xfer;
    logic [LOG2N-1:0] rd_addr;
    logic [2*DW-1:0]  wr_data;
    logic [2*DW-1:0]  rd_data;

    assign filling  = (state_q == StFill);
    assign draining = (state_q == StDrain);

    // in_ready is exactly 'filling', so an input transfer only needs in_valid in FILL.
    assign in_xfer  = filling & bus_io.in_valid;
    assign out_xfer = draining & bus_io.out_ready;

    assign wr_data  = {bus_io.in_re, bus_io.in_im};

    // Replay address. The buffer is not written while draining, so the presented word is
    // stable under backpressure as long as rd_idx holds.
    always_comb begin
        if (BITREV) begin
            rd_addr = LOG2N'(bitrev(MaxLog2n'(rd_idx_q), LOG2N));
        end else begin
            rd_addr = rd_idx_q;
        end
    end

    qpsk_frame_loader_frame_ram #(
        .LOG2N (LOG2N),
        .DW    (DW)
    ) u_frame_ram (
        .clk_i   (clk),
        .we_i    (in_xfer),
        .waddr_i (wr_idx_q),
        .wdata_i (wr_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Next-state logic: FSM and index/frame counters.
    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        frame_count_d = frame_count_q;

        unique case (state_q)
            StFill: begin
                if (in_xfer) begin
                    wr_idx_d = wr_idx_q + LOG2N'(1);
                    if (wr_idx_q == LastIdx) begin
                        wr_idx_d = '0;
                        state_d  = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_xfer) begin
                    rd_idx_d = rd_idx_q + LOG2N'(1);
                    if (rd_idx_q == LastIdx) begin
                        rd_idx_d      = '0;
                        frame_count_d = frame_count_q + 16'd1;
                        state_d       = StFill;
                    end
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StFill;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Output gating: data and frame markers are forced to zero whenever out_valid is low.
    // Everything here depends on state only, so reset clears the outputs immediately.
    always_comb begin
        bus_io.in_ready  = filling;
        bus_io.out_valid = draining;
        bus_io.out_re    = '0;
        bus_io.out_im    = '0;
        bus_io.out_first = 1'b0;
        bus_io.out_last  = 1'b0;
        if (draining) begin
            bus_io.out_re    = rd_data[2*DW-1:DW];
            bus_io.out_im    = rd_data[DW-1:0];
            bus_io.out_first = (rd_idx_q == '0);
            bus_io.out_last  = (rd_idx_q == LastIdx);
        end
    end

    assign frame_count_o = frame_count_q;

endmodule
